instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 64: instruction memory size in 32-bit words, a power of 2.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000: first fetch address after start.
REQ-003 The block SHALL have these ports, one per line:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_en  input  1  write enable for instruction memory.
- load_addr  input  log2(IMEM_DEPTH)  word address for the write.
- load_data  input  32  instruction word to write.
- start  input  1  begins fetching from RESET_PC.
- stall  input  1  datapath holds the current instruction.
- redirect  input  1  branch or jump taken.
- redirect_pc  input  32  byte target address for the redirect.
- instr  output  32  instruction presented to the datapath.
- pc  output  32  byte address of instr.
- instr_valid  output  1  instr/pc are valid.
- halted  output  1  ECALL fetched; fetching stopped.
- fault  output  1  misaligned or out-of-range fetch address.

Function
REQ-004 The block SHALL have four states: IDLE, RUN, HALT and FAULT.
REQ-005 In IDLE or HALT, a load_en pulse SHALL write load_data to imem[load_addr] on the clock edge.
REQ-006 In RUN or FAULT, load_en SHALL be ignored.
REQ-007 IDLE -> RUN SHALL occur on start=1; the fetch address on that edge is RESET_PC.
REQ-008 In IDLE, state otherwise holds.
REQ-009 In RUN, on each edge with stall=0:
- fetch address fa = redirect ? redirect_pc : pc+4.
- instr <= imem[fa[2+:log2(IMEM_DEPTH)]].
- pc <= fa.
- instr_valid <= 1.
REQ-010 Fetch latency SHALL be one cycle: the word for the address chosen at edge N is on instr after edge N.
REQ-011 In RUN with stall=1, instr, pc and instr_valid SHALL hold.
REQ-012 When stall=1 and redirect=1 together, redirect SHALL be ignored (stall wins).
REQ-013 Before any fetch, the SHALL check fa:
- if fa[1:0] != 0 or fa >= 4*IMEM_DEPTH, go to FAULT with no fetch.
- in FAULT: fault=1, instr_valid=0, instr=32'h00000013 (NOP), pc=fa.
REQ-014 When a fetched word equals 32'h00000073 (ECALL), it SHALL be presented with instr_valid=1 for one cycle; on the next edge the state goes to HALT.
REQ-015 In HALT: halted=1, instr_valid=0, instr=NOP, pc holds.
REQ-016 start in HALT SHALL clear halted and re-enter RUN at RESET_PC, as from IDLE.
REQ-017 FAULT SHALL be exited only by reset; start and load_en are ignored there.
REQ-018 PC arithmetic SHALL be 32-bit unsigned; pc+4 wrap past 32'hFFFFFFFC is caught as out-of-range by REQ-013.
REQ-019 Instruction memory contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-020 rst_n=0 SHALL immediately (asynchronously) force:
- state=IDLE, instr=32'h00000013, pc=RESET_PC, instr_valid=0, halted=0, fault=0.
REQ-021 Reset asserted mid-RUN SHALL abort fetching; no memory write occurs while rst_n=0.
REQ-022 Deassertion of rst_n SHALL take effect at the next rising edge.

Verification
REQ-023 Load, start, run:
- load imem[0]=32'h015A04B3, imem[1]=32'h00148593, imem[2]=32'h00000073, then pulse start.
- edge 1: instr=015A04B3, pc=0, valid=1; edge 2: 00148593, pc=4; edge 3: 00000073, pc=8; edge 4: halted=1, valid=0, instr=00000013.
REQ-024 Stall: in RUN with instr=015A04B3, hold stall=1 for 3 cycles -> instr and pc unchanged, valid stays 1; release -> next edge shows 00148593, pc=4.
REQ-025 Redirect and stall+redirect:
- redirect=1, redirect_pc=8 at pc=0 -> next instr=imem[2], pc=8.
- stall=1 with redirect=1 -> no change.
REQ-026 Fault:
- redirect_pc=32'h6 -> fault=1, pc=6, valid=0, instr=NOP; start ignored afterwards.
- redirect_pc=4*IMEM_DEPTH -> same fault response.
REQ-027 Async reset mid-RUN: drop rst_n between edges -> outputs reach reset values before the next edge.
REQ-028 Reset preserves memory: after reset, start reruns the REQ-023 sequence identically without reloading.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Single-cycle instruction fetch with loadable local memory,
//               stall/redirect handling, ECALL halt and alignment/range fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          redirect,
    input  logic [31:0]                   redirect_pc,
    output logic [31:0]                   instr,
    output logic [31:0]                   pc,
    output logic                          instr_valid,
    output logic                          halted,
    output logic                          fault
);

    localparam int          c_AW        = $clog2(IMEM_DEPTH);
    localparam logic [31:0] c_NOP       = 32'h00000013;
    localparam logic [31:0] c_ECALL     = 32'h00000073;
    localparam logic [31:0] c_MEM_BYTES = 32'(4 * IMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_imem [IMEM_DEPTH];

    logic [31:0] w_fa;
    logic        w_fa_bad;
    logic [31:0] w_fetch_word;
    logic        w_ecall_out;
    logic        w_launch;
    logic        w_mem_we;

    // A launch from IDLE/HALT always targets RESET_PC; in RUN the next address
    // is either the redirect target or the sequential successor.
    always_comb begin
        w_fa = RESET_PC;
        if (r_state == RUN) begin
            w_fa = redirect ? redirect_pc : (pc + 32'd4);
        end
    end

    assign w_fa_bad     = (w_fa[1:0] != 2'b00) || (w_fa >= c_MEM_BYTES);
    assign w_fetch_word = r_imem[w_fa[2 +: c_AW]];
    assign w_ecall_out  = (r_state == RUN) && instr_valid && (instr == c_ECALL);
    assign w_launch     = (((r_state == IDLE) || (r_state == HALT)) && start) ||
                          ((r_state == RUN) && !stall && !w_ecall_out);
    assign w_mem_we     = rst_n && load_en && ((r_state == IDLE) || (r_state == HALT));

    // Memory has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_imem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            instr       <= c_NOP;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else if (w_ecall_out) begin
            // ECALL was shown for exactly one cycle; stop here, pc keeps its address.
            r_state     <= HALT;
            instr       <= c_NOP;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
        end else if (w_launch) begin
            halted <= 1'b0;
            pc     <= w_fa;
            if (w_fa_bad) begin
                r_state     <= FAULT;
                instr       <= c_NOP;
                instr_valid <= 1'b0;
                fault       <= 1'b1;
            end else begin
                r_state     <= RUN;
                instr       <= w_fetch_word;
                instr_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed scoreboard bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic        f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        halted;
    logic        fault;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h00000000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .pc         (pc),
        .instr_valid(instr_valid),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p,
                                input logic v, input logic h, input logic f);
        exp_t e;
        e.instr = i; e.pc = p; e.v = v; e.h = h; e.f = f;
        return e;
    endfunction

    task automatic compare(input exp_t e, input string nm);
        exp_t a;
        a = mk(instr, pc, instr_valid, halted, fault);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got instr=%08h pc=%08h v=%b h=%b f=%b, want instr=%08h pc=%08h v=%b h=%b f=%b",
                      nm, a.instr, a.pc, a.v, a.h, a.f, e.instr, e.pc, e.v, e.h, e.f);
    endtask

    // Monitor: after every rising edge, check the result predicted for it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) compare(exp_q.pop_front(), name_q.pop_front());
        end
    end

    // Inputs are already set; optionally queue the outcome of the coming edge.
    task automatic cyc(input bit chk, input exp_t e, input string nm);
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        load_en = 0; start = 0; stall = 0; redirect = 0; redirect_pc = 0;
    endtask

    task automatic run_base_seq(input string tag);
        start = 1;
        cyc(1, mk(32'h015A04B3, 32'h0, 1, 0, 0), {tag, "_e1"});
        start = 0;
        cyc(1, mk(32'h00148593, 32'h4, 1, 0, 0), {tag, "_e2"});
        cyc(1, mk(32'h00000073, 32'h8, 1, 0, 0), {tag, "_e3"});
        cyc(1, mk(NOP,          32'h8, 0, 1, 0), {tag, "_halt"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        compare(mk(NOP, 32'h0, 0, 0, 0), "reset_state");
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h015A04B3; prog[1] = 32'h00148593;
        prog[2] = 32'h00000073; prog[3] = 32'h00208133;
        rst_n = 0; load_addr = 0; load_data = 0;
        idle_inputs();
        #12;
        compare(mk(NOP, 32'h0, 0, 0, 0), "por_reset");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 4; i++) begin
            load_en = 1; load_addr = 6'(i); load_data = prog[i];
            cyc(0, '0, "");
        end
        load_en = 0;

        run_base_seq("seq");
        cyc(1, mk(NOP, 32'h8, 0, 1, 0), "halt_hold");

        // Stall for three cycles; a load attempted during RUN must be dropped.
        start = 1;
        cyc(1, mk(32'h015A04B3, 32'h0, 1, 0, 0), "restart");
        start = 0; stall = 1;
        load_en = 1; load_addr = 6'd1; load_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) cyc(1, mk(32'h015A04B3, 32'h0, 1, 0, 0), "stall_hold");
        load_en = 0; stall = 0;
        cyc(1, mk(32'h00148593, 32'h4, 1, 0, 0), "stall_release");

        stall = 1; redirect = 1; redirect_pc = 32'h0;
        cyc(1, mk(32'h00148593, 32'h4, 1, 0, 0), "stall_beats_redirect");
        stall = 0; redirect_pc = 32'hC;
        cyc(1, mk(32'h00208133, 32'hC, 1, 0, 0), "redirect_c");
        redirect_pc = 32'h0;
        cyc(1, mk(32'h015A04B3, 32'h0, 1, 0, 0), "redirect_0");
        redirect_pc = 32'h8;
        cyc(1, mk(32'h00000073, 32'h8, 1, 0, 0), "redirect_8");
        redirect = 0;
        cyc(1, mk(NOP, 32'h8, 0, 1, 0), "redirect_halt");

        // Asynchronous reset mid-RUN with a load request that must not land.
        start = 1;
        cyc(1, mk(32'h015A04B3, 32'h0, 1, 0, 0), "pre_async");
        start = 0;
        #2;
        rst_n = 0; load_en = 1; load_addr = 6'd0; load_data = 32'hFFFFFFFF;
        #1;
        compare(mk(NOP, 32'h0, 0, 0, 0), "async_reset");
        @(negedge clk);
        load_en = 0;
        rst_n = 1;
        run_base_seq("rerun");

        // Misaligned redirect faults; start and load are then ignored.
        start = 1;
        cyc(1, mk(32'h015A04B3, 32'h0, 1, 0, 0), "pre_fault");
        start = 0; redirect = 1; redirect_pc = 32'h6;
        cyc(1, mk(NOP, 32'h6, 0, 0, 1), "fault_misalign");
        redirect = 0; start = 1;
        load_en = 1; load_addr = 6'd0; load_data = 32'h12345678;
        cyc(1, mk(NOP, 32'h6, 0, 0, 1), "fault_start_ignored");
        start = 0; load_en = 0;

        do_reset();
        start = 1;
        cyc(1, mk(32'h015A04B3, 32'h0, 1, 0, 0), "pre_fault2");
        start = 0; redirect = 1; redirect_pc = 32'(4 * DEPTH);
        cyc(1, mk(NOP, 32'(4 * DEPTH), 0, 0, 1), "fault_range");
        redirect = 0;
        cyc(1, mk(NOP, 32'(4 * DEPTH), 0, 0, 1), "fault_hold");

        cyc(0, '0, "");
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
